pll_supervisor: RTL and testbench

PLL_SUPERVISOR -- requirements
Module: pll_supervisor

---
 rtl/pll_sup_pkg.sv | 19 +
 rtl/pll_supervisor_clk_en_div.sv | 46 ++++
 rtl/pll_supervisor.sv | 144 ++++++++++++++
 tb/tb_pll_supervisor.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_sup_pkg.sv
// Shared state encoding and elaboration helpers for the PLL supervisor.
// The state values are exported on the debug port, so they must stay fixed.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    ST_HOLD   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAIL   = 3'd4
  } sup_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_supervisor_clk_en_div.sv
// One clock-enable divider channel: emits a single-cycle pulse every D cycles while running.
// D is re-sampled only at RUN entry and at each wrap, so mid-period divisor changes wait for the next pulse.
module clk_en_div #(
  parameter int DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             run_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             ce_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] last;

  // Divisors of 0 and 1 both mean "pulse every cycle".
  assign last = (div_q <= DIV_W'(1)) ? '0 : (div_q - DIV_W'(1));
  assign ce_o = run_i && (cnt_q == last);

  // Outside RUN the divisor tracks the input, so the entry edge latches it.
  always_comb begin
    cnt_d = '0;
    div_d = div_i;
    if (run_i) begin
      if (cnt_q == last) begin
        cnt_d = '0;
        div_d = div_i;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
        div_d = div_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      div_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/pll_supervisor.sv
// PLL reset/lock supervisor: pulses the PLL reset, waits for a stable lock with bounded retries,
// and gates the per-channel clock-enable dividers so they only run while the PLL is trusted.
module pll_supervisor
  import pll_sup_pkg::*;
#(
  parameter int N_CH         = 2,
  parameter int DIV_W        = 16,
  parameter int RST_HOLD_CYC = 16,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int STABLE_CYC   = 1024,
  parameter int MAX_RETRY    = 3
) (
  input  logic                             clkin,
  input  logic                             reset_n,
  input  logic                             pll_lock,
  output logic                             pll_reset,
  input  logic [N_CH*DIV_W-1:0]            div_val,
  output logic [N_CH-1:0]                  ce,
  output logic                             ready,
  output logic                             fail,
  output logic [$clog2(MAX_RETRY+1)-1:0]   retry_cnt,
  output logic [2:0]                       state
);

  localparam int RC_W    = $clog2(MAX_RETRY + 1);
  // One shared phase timer; STABLE needs to hold the value STABLE_CYC itself.
  localparam int TMR_MAX = max3(RST_HOLD_CYC, LOCK_TIMEOUT, STABLE_CYC + 1);
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [TMR_W-1:0] HOLD_LAST    = TMR_W'(RST_HOLD_CYC - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] STABLE_DONE  = TMR_W'(STABLE_CYC);
  localparam logic [RC_W-1:0]  RETRY_LIMIT  = RC_W'(MAX_RETRY);

  sup_state_e        state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [RC_W-1:0]   retry_q, retry_d;
  logic [1:0]        sync_q;
  logic              lock_s;
  logic              run;

  // pll_lock is asynchronous to clkin; only the second flop's output is trusted.
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], pll_lock};
    end
  end

  assign lock_s = sync_q[1];

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_HOLD;
      tmr_q   <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      retry_q <= retry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    retry_d = retry_q;
    case (state_q)
      ST_HOLD: begin
        if (tmr_q == HOLD_LAST) begin
          state_d = ST_WAIT;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_WAIT: begin
        if (lock_s) begin
          state_d = ST_STABLE;
          tmr_d   = '0;
        end else if (tmr_q == TIMEOUT_LAST) begin
          tmr_d = '0;
          if (retry_q == RETRY_LIMIT) begin
            state_d = ST_FAIL;
          end else begin
            retry_d = retry_q + RC_W'(1);
            state_d = ST_HOLD;
          end
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      // Any dropout restarts both the stable count and the lock timeout.
      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT;
          tmr_d   = '0;
        end else if (tmr_q == STABLE_DONE) begin
          state_d = ST_RUN;
          tmr_d   = '0;
          retry_d = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d = ST_HOLD;
          tmr_d   = '0;
        end
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d = ST_HOLD;
        tmr_d   = '0;
        retry_d = '0;
      end
    endcase
  end

  // Outputs decode straight from the state register so reset forces them immediately.
  assign run       = (state_q == ST_RUN);
  assign ready     = run;
  assign fail      = (state_q == ST_FAIL);
  assign pll_reset = (state_q == ST_HOLD) || (state_q == ST_FAIL);
  assign retry_cnt = retry_q;
  assign state     = state_q;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    clk_en_div #(
      .DIV_W(DIV_W)
    ) u_div (
      .clk_i (clkin),
      .rst_ni(reset_n),
      .run_i (run),
      .div_i (div_val[k*DIV_W +: DIV_W]),
      .ce_o  (ce[k])
    );
  end

endmodule

// File: tb/tb_pll_supervisor.sv
// Bench for pll_supervisor: directed timing sequences, a divisor table, and random lock/divisor
// traffic, all compared every cycle against a phase-level reference model.
module tb_pll_supervisor;

  localparam int N_CH     = 2;
  localparam int DIV_W    = 8;
  localparam int RST_HOLD = 4;
  localparam int STABLE   = 8;
  localparam int TIMEOUT  = 20;
  localparam int MAXR     = 2;

  logic                  clkin = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  pll_lock = 1'b0;
  logic [N_CH*DIV_W-1:0] div_val = '0;
  logic                  pll_reset, ready, fail;
  logic [N_CH-1:0]       ce;
  logic [1:0]            retry_cnt;
  logic [2:0]            state;

  int passCount = 0;
  int checkCount = 0;

  // Model: phase 0..4 is the expected state code, phaseCnt counts cycles/locks in the phase.
  int mPhase, mCnt, mRetry;
  bit mSync1, mSync2;
  int mPos[N_CH];
  int mPer[N_CH];

  typedef struct {
    int d0;
    int d1;
    int first0;
    int first1;
    int gap0;
    int gap1;
  } divVec_t;

  divVec_t tbl[5];

  always #10 clkin = ~clkin;

  pll_supervisor #(
    .N_CH(N_CH), .DIV_W(DIV_W), .RST_HOLD_CYC(RST_HOLD),
    .LOCK_TIMEOUT(TIMEOUT), .STABLE_CYC(STABLE), .MAX_RETRY(MAXR)
  ) dut (
    .clkin(clkin), .reset_n(reset_n), .pll_lock(pll_lock), .pll_reset(pll_reset),
    .div_val(div_val), .ce(ce), .ready(ready), .fail(fail),
    .retry_cnt(retry_cnt), .state(state)
  );

  function automatic int effDiv(input int d);
    return (d <= 1) ? 1 : d;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
  endtask

  task automatic modelReset();
    mPhase = 0; mCnt = 0; mRetry = 0; mSync1 = 0; mSync2 = 0;
    for (int ch = 0; ch < N_CH; ch++) begin
      mPos[ch] = 1;
      mPer[ch] = 1;
    end
  endtask

  // Advance the model across one clock edge using the inputs as they stood before it.
  task automatic modelStep();
    bit lockS;
    bit wasRun;
    lockS = mSync2;
    wasRun = (mPhase == 3);
    for (int ch = 0; ch < N_CH; ch++) begin
      if (wasRun && mPos[ch] != mPer[ch]) begin
        mPos[ch]++;
      end else begin
        mPos[ch] = 1;
        mPer[ch] = effDiv(int'(div_val[ch*DIV_W +: DIV_W]));
      end
    end
    case (mPhase)
      0: begin
        mCnt++;
        if (mCnt == RST_HOLD) begin mPhase = 1; mCnt = 0; end
      end
      1: begin
        if (lockS) begin
          mPhase = 2; mCnt = 0;
        end else begin
          mCnt++;
          if (mCnt == TIMEOUT) begin
            mCnt = 0;
            if (mRetry == MAXR) mPhase = 4;
            else begin mRetry++; mPhase = 0; end
          end
        end
      end
      2: begin
        if (!lockS) begin
          mPhase = 1; mCnt = 0;
        end else begin
          mCnt++;
          if (mCnt > STABLE) begin mPhase = 3; mCnt = 0; mRetry = 0; end
        end
      end
      3: if (!lockS) begin mPhase = 0; mCnt = 0; end
      default: ;
    endcase
    mSync2 = mSync1;
    mSync1 = pll_lock;
  endtask

  task automatic checkModel();
    logic [9:0] expV, actV;
    logic [1:0] expCe;
    for (int ch = 0; ch < N_CH; ch++) expCe[ch] = (mPhase == 3) && (mPos[ch] == mPer[ch]);
    expV = {3'(mPhase), (mPhase == 0) || (mPhase == 4), mPhase == 3, mPhase == 4, 2'(mRetry), expCe};
    actV = {state, pll_reset, ready, fail, retry_cnt, ce};
    checkOutput("modelOutputs", int'(actV), int'(expV));
  endtask

  task automatic tick();
    @(posedge clkin);
    if (reset_n) modelStep();
    #1;
    checkModel();
  endtask

  task automatic setDiv(input int d0, input int d1);
    div_val = {DIV_W'(d1), DIV_W'(d0)};
  endtask

  task automatic doReset();
    #4;
    reset_n = 1'b0;
    modelReset();
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic applyStimulus(input int cycles);
    int segLeft;
    segLeft = 0;
    for (int i = 0; i < cycles; i++) begin
      if (segLeft == 0) begin
        pll_lock = !pll_lock;
        if (pll_lock) segLeft = $urandom_range(5, 80);
        else if ($urandom_range(0, 7) == 0) segLeft = $urandom_range(20, 50);
        else segLeft = $urandom_range(1, 4);
      end
      segLeft--;
      if ($urandom_range(0, 39) == 0) setDiv($urandom_range(0, 9), $urandom_range(0, 9));
      if ($urandom_range(0, 399) == 0) doReset();
      else tick();
    end
  endtask

  initial begin
    int n, holdCnt, g, first0, first1, second0, second1;
    bit prevRst, sawWait;
    int retryQ[$];
    int expRetry[3];

    tbl[0] = '{5, 1, 5, 1, 5, 1};
    tbl[1] = '{0, 3, 1, 3, 1, 3};
    tbl[2] = '{2, 7, 2, 7, 2, 7};
    tbl[3] = '{1, 0, 1, 1, 1, 1};
    tbl[4] = '{9, 4, 9, 4, 9, 4};
    expRetry = '{0, 1, 2};

    modelReset();
    #5;
    checkOutput("rstState", int'(state), 0);
    checkOutput("rstPllReset", int'(pll_reset), 1);
    checkOutput("rstReady", int'(ready), 0);
    checkOutput("rstFail", int'(fail), 0);
    checkOutput("rstCe", int'(ce), 0);
    checkOutput("rstRetry", int'(retry_cnt), 0);
    tick();
    tick();
    reset_n = 1'b1;
    setDiv(5, 1);

    // Power-up lock: hold length, lock-to-ready latency, divider phases.
    holdCnt = 1; n = 0;
    while (pll_reset && n < 100) begin
      tick(); n++;
      if (pll_reset) holdCnt++;
    end
    checkOutput("holdLen", holdCnt, RST_HOLD);
    repeat (5) tick();
    pll_lock = 1'b1;
    tick();
    n = 0;
    while (!ready && n < 100) begin tick(); n++; end
    checkOutput("lockToReady", n, 11);
    checkOutput("runRetry", int'(retry_cnt), 0);
    checkOutput("ce1FirstRunCycle", int'(ce[1]), 1);
    n = 1;
    while (!ce[0] && n < 50) begin tick(); n++; end
    checkOutput("ce0First", n, 5);
    tick(); tick(); g = 2;
    setDiv(3, 1);
    while (!ce[0] && g < 50) begin tick(); g++; end
    checkOutput("ce0GapOld", g, 5);
    g = 0;
    do begin tick(); g++; end while (!ce[0] && g < 50);
    checkOutput("ce0GapNew", g, 3);

    // Lock lost in RUN, then relock.
    pll_lock = 1'b0;
    n = 0;
    while (ready && n < 20) begin tick(); n++; end
    checkOutput("lossToNotReady", n, 3);
    checkOutput("lossCe", int'(ce), 0);
    holdCnt = 1; n = 0;
    while (pll_reset && n < 100) begin
      tick(); n++;
      if (pll_reset) holdCnt++;
    end
    checkOutput("relockHoldLen", holdCnt, RST_HOLD);
    pll_lock = 1'b1;
    n = 0;
    while (!ready && n < 200) begin tick(); n++; end
    checkOutput("relockReady", int'(ready), 1);
    checkOutput("relockRetry", int'(retry_cnt), 0);

    // Reset mid-RUN acts within the same cycle.
    #5;
    reset_n = 1'b0;
    modelReset();
    #1;
    checkOutput("midRstState", int'(state), 0);
    checkOutput("midRstPllReset", int'(pll_reset), 1);
    checkOutput("midRstReady", int'(ready), 0);
    checkOutput("midRstCe", int'(ce), 0);
    tick(); tick();
    reset_n = 1'b1;

    // One-cycle lock glitch during STABLE.
    n = 0;
    while (state != 3'd2 && n < 100) begin tick(); n++; end
    repeat (3) tick();
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    sawWait = 0; n = 0;
    while (!sawWait && n < 10) begin tick(); n++; sawWait = (state == 3'd1); end
    checkOutput("glitchToWait", int'(sawWait), 1);
    n = 0;
    while (!ready && n < 100) begin tick(); n++; end
    checkOutput("glitchWaitToReady", n, STABLE + 2);

    // Lock never arrives: three attempts, then terminal FAIL.
    pll_lock = 1'b0;
    doReset();
    n = 0; prevRst = pll_reset;
    while (!fail && n < 300) begin
      tick(); n++;
      if (prevRst && !pll_reset) retryQ.push_back(int'(retry_cnt));
      prevRst = pll_reset;
    end
    checkOutput("cyclesToFail", n, 3 * (RST_HOLD + TIMEOUT));
    checkOutput("retryAttempts", retryQ.size(), 3);
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("retrySeq%0d", i), (i < retryQ.size()) ? retryQ[i] : -1, expRetry[i]);
    pll_lock = 1'b1;
    repeat (30) tick();
    checkOutput("failHeld", int'(fail), 1);
    checkOutput("failState", int'(state), 4);
    checkOutput("failPllReset", int'(pll_reset), 1);
    checkOutput("failRetry", int'(retry_cnt), MAXR);

    // Divisor table: first pulse position and period per channel.
    for (int r = 0; r < 5; r++) begin
      pll_lock = 1'b0;
      doReset();
      setDiv(tbl[r].d0, tbl[r].d1);
      pll_lock = 1'b1;
      n = 0;
      while (!ready && n < 200) begin tick(); n++; end
      checkOutput($sformatf("tbl%0dReady", r), int'(ready), 1);
      first0 = -1; first1 = -1; second0 = -1; second1 = -1;
      for (int c = 1; c <= 25; c++) begin
        if (ce[0]) begin
          if (first0 < 0) first0 = c;
          else if (second0 < 0) second0 = c;
        end
        if (ce[1]) begin
          if (first1 < 0) first1 = c;
          else if (second1 < 0) second1 = c;
        end
        tick();
      end
      checkOutput($sformatf("tbl%0dFirst0", r), first0, tbl[r].first0);
      checkOutput($sformatf("tbl%0dFirst1", r), first1, tbl[r].first1);
      checkOutput($sformatf("tbl%0dGap0", r), second0 - first0, tbl[r].gap0);
      checkOutput($sformatf("tbl%0dGap1", r), second1 - first1, tbl[r].gap1);
    end

    // Random lock dropouts, divisor changes and occasional resets.
    pll_lock = 1'b0;
    doReset();
    applyStimulus(3000);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
